// File: rtl/jtsdram_slot.sv
// jtsdram_slot: one-request slot between a bank tester and the shared SDRAM
// controller port. Latches a tester request, handshakes it to the controller,
// assembles two 16-bit read beats into a 32-bit word, and returns it with an
// ack/rdy pair. A cycle counter drives a sticky timeout and a worst-case
// latency record for the debug overlay.
module jtsdram_slot #(
    parameter int TOUT = 255,
    parameter int AW   = 22
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd,
    input  logic          wr,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   din,
    output logic          ack,
    output logic          rdy,
    output logic [31:0]   data_read,
    output logic          sdram_req,
    output logic          sdram_rnw,
    output logic [AW-1:0] sdram_addr,
    output logic [15:0]   sdram_din,
    input  logic          sdram_ack,
    input  logic          sdram_dst,
    input  logic          sdram_rdy,
    input  logic [15:0]   sdram_dout,
    output logic          busy,
    output logic          timeout,
    output logic [7:0]    lat_max
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    localparam logic [7:0] TOUT8 = 8'(TOUT);

    state_t        state_q, state_d;
    logic          ack_q, ack_d;
    logic          rdy_q, rdy_d;
    logic [31:0]   data_read_q, data_read_d;
    logic          req_q, req_d;
    logic          rnw_q, rnw_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0]   din_q, din_d;
    logic          busy_q, busy_d;
    logic          timeout_q, timeout_d;
    logic [7:0]    lat_max_q, lat_max_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [1:0]    beat_q, beat_d;
    logic [7:0]    cnt_inc;

    // Next-state logic: request latch, controller handshake, beat capture,
    // completion/timeout and latency tracking.
    always_comb begin
        state_d     = state_q;
        ack_d       = 1'b0;
        rdy_d       = 1'b0;
        data_read_d = data_read_q;
        req_d       = req_q;
        rnw_d       = rnw_q;
        addr_d      = addr_q;
        din_d       = din_q;
        timeout_d   = timeout_q;
        lat_max_d   = lat_max_q;
        cnt_d       = cnt_q;
        beat_d      = beat_q;
        // Saturating increment; also equals counter+1 for the latency record.
        cnt_inc     = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

        unique case (state_q)
            IDLE: begin
                if (rd || wr) begin
                    addr_d  = addr;
                    din_d   = din;
                    rnw_d   = rd;
                    beat_d  = 2'd0;
                    cnt_d   = 8'd0;
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                cnt_d = cnt_inc;
                if (cnt_q == TOUT8) begin
                    // Controller never accepted: give up without an ack.
                    req_d     = 1'b0;
                    timeout_d = 1'b1;
                    rdy_d     = 1'b1;
                    lat_max_d = (cnt_inc > lat_max_q) ? cnt_inc : lat_max_q;
                    state_d   = IDLE;
                end else if (sdram_ack) begin
                    req_d   = 1'b0;
                    ack_d   = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_inc;
                // Only the first two read beats land; extras are dropped.
                if (rnw_q && sdram_dst && beat_q < 2'd2) begin
                    if (beat_q == 2'd0) data_read_d[15:0]  = sdram_dout;
                    else                data_read_d[31:16] = sdram_dout;
                    beat_d = beat_q + 2'd1;
                end
                if (cnt_q == TOUT8 || sdram_rdy) begin
                    if (cnt_q == TOUT8) timeout_d = 1'b1;
                    req_d     = 1'b0;
                    rdy_d     = 1'b1;
                    lat_max_d = (cnt_inc > lat_max_q) ? cnt_inc : lat_max_q;
                    state_d   = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ack_q       <= 1'b0;
            rdy_q       <= 1'b0;
            data_read_q <= 32'd0;
            req_q       <= 1'b0;
            rnw_q       <= 1'b1;
            addr_q      <= '0;
            din_q       <= 16'd0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            lat_max_q   <= 8'd0;
            cnt_q       <= 8'd0;
            beat_q      <= 2'd0;
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            rdy_q       <= rdy_d;
            data_read_q <= data_read_d;
            req_q       <= req_d;
            rnw_q       <= rnw_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
            lat_max_q   <= lat_max_d;
            cnt_q       <= cnt_d;
            beat_q      <= beat_d;
        end
    end

    assign ack        = ack_q;
    assign rdy        = rdy_q;
    assign data_read  = data_read_q;
    assign sdram_req  = req_q;
    assign sdram_rnw  = rnw_q;
    assign sdram_addr = addr_q;
    assign sdram_din  = din_q;
    assign busy       = busy_q;
    assign timeout    = timeout_q;
    assign lat_max    = lat_max_q;

endmodule

// File: tb/tb_jtsdram_slot.sv
// Directed bench for jtsdram_slot: a controller model driven from one linear
// initial block, with a scoreboard queue of expected read words popped on rdy.
module tb_jtsdram_slot;

    localparam int AW   = 22;
    localparam int TOUT = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd, wr;
    logic [AW-1:0] addr;
    logic [15:0]   din;
    logic          ack, rdy;
    logic [31:0]   data_read;
    logic          sdram_req, sdram_rnw;
    logic [AW-1:0] sdram_addr;
    logic [15:0]   sdram_din;
    logic          sdram_ack, sdram_dst, sdram_rdy;
    logic [15:0]   sdram_dout;
    logic          busy, timeout;
    logic [7:0]    lat_max;

    int checks   = 0;
    int failures = 0;
    int n_ack    = 0;
    int n_rdy    = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_data;
    int          exp_lat;

    jtsdram_slot #(.TOUT(TOUT), .AW(AW)) dut (
        .clk(clk), .rst(rst), .rd(rd), .wr(wr), .addr(addr), .din(din),
        .ack(ack), .rdy(rdy), .data_read(data_read),
        .sdram_req(sdram_req), .sdram_rnw(sdram_rnw), .sdram_addr(sdram_addr),
        .sdram_din(sdram_din), .sdram_ack(sdram_ack), .sdram_dst(sdram_dst),
        .sdram_rdy(sdram_rdy), .sdram_dout(sdram_dout),
        .busy(busy), .timeout(timeout), .lat_max(lat_max)
    );

    always #5 clk = ~clk;

    // Pulse counters for handshake outputs.
    always @(negedge clk) begin
        if (ack) n_ack++;
        if (rdy) n_rdy++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_pop(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=rdy expected=no_pending", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, data_read, e);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_data = 32'd0;
        exp_lat  = 0;
        exp_q.delete();
    endtask

    // One transfer: ack sampled ack_dly edges after latch, then nbeats dst
    // cycles, then gap idle cycles and an sdram_rdy cycle (or rdy on the last
    // beat when coin is set). Tester holds rd/wr one cycle past ack.
    task automatic xfer(input logic rnw, input logic [AW-1:0] a, input logic [15:0] d,
                        input int ack_dly, input int nbeats,
                        input logic [15:0] b0, input logic [15:0] b1,
                        input int gap, input bit coin);
        int lat, n;
        if (rnw) begin
            if (nbeats > 0) exp_data[15:0]  = b0;
            if (nbeats > 1) exp_data[31:16] = b1;
        end
        exp_q.push_back(exp_data);
        lat = ack_dly + nbeats + (coin ? 0 : gap + 1);
        if (lat > exp_lat) exp_lat = lat;
        n = nbeats + (coin ? 0 : gap + 1);

        rd = rnw; wr = !rnw; addr = a; din = d;
        @(negedge clk);
        chk("req_rise", 32'(sdram_req), 32'd1);
        chk("req_addr", 32'(sdram_addr), 32'(a));
        chk("req_rnw", 32'(sdram_rnw), 32'(rnw));
        if (!rnw) chk("req_din", 32'(sdram_din), 32'(d));
        chk("busy_req", 32'(busy), 32'd1);
        repeat (ack_dly - 1) @(negedge clk);
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        chk("ack_pulse", 32'(ack), 32'd1);
        chk("req_drop", 32'(sdram_req), 32'd0);
        for (int i = 0; i < n; i++) begin
            sdram_dst  = (i < nbeats);
            sdram_dout = (i == 0) ? b0 : (i == 1) ? b1 : 16'hDEAD;
            sdram_rdy  = (i == n - 1);
            @(negedge clk);
            rd = 1'b0; wr = 1'b0;
            if (i < n - 1) chk("no_early_rdy", 32'(rdy), 32'd0);
        end
        sdram_dst = 1'b0;
        sdram_rdy = 1'b0;
        chk("rdy_pulse", 32'(rdy), 32'd1);
        chk("busy_done", 32'(busy), 32'd0);
        sb_pop("data_read");
        chk("lat_max", 32'(lat_max), 32'(exp_lat));
    endtask

    initial begin
        int a0, r0, k;
        rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; din = 16'd0;
        sdram_ack = 1'b0; sdram_dst = 1'b0; sdram_rdy = 1'b0; sdram_dout = 16'd0;
        exp_data = 32'd0; exp_lat = 0;
        do_reset();

        // Reset values
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_rdy", 32'(rdy), 32'd0);
        chk("rst_req", 32'(sdram_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_data", data_read, 32'd0);
        chk("rst_lat", 32'(lat_max), 32'd0);
        chk("rst_rnw", 32'(sdram_rnw), 32'd1);
        chk("rst_addr", 32'(sdram_addr), 32'd0);
        chk("rst_din", 32'(sdram_din), 32'd0);

        // Read with ack 3 cycles after req, two beats, then rdy
        xfer(1'b1, 22'h00123, 16'h0000, 3, 2, 16'hBEEF, 16'h1234, 0, 1'b0);
        chk("read_word", data_read, 32'h1234BEEF);

        // Write: dst pulses must not disturb data_read
        xfer(1'b0, 22'h00456, 16'hA5A5, 2, 2, 16'h1111, 16'h2222, 1, 1'b0);
        chk("write_keeps_data", data_read, 32'h1234BEEF);

        // Back-to-back reads, one with a third beat, one with dst/rdy coinciding
        #1; a0 = n_ack; r0 = n_rdy;
        xfer(1'b1, 22'h00010, 16'h0, 1, 2, 16'h0A0A, 16'h0B0B, 0, 1'b0);
        xfer(1'b1, 22'h00020, 16'h0, 2, 2, 16'hC0DE, 16'hFACE, 0, 1'b1);
        xfer(1'b1, 22'h00030, 16'h0, 1, 3, 16'h5555, 16'h6666, 2, 1'b0);
        xfer(1'b1, 22'h3FFFF, 16'h0, 4, 1, 16'h9999, 16'h0000, 0, 1'b1);
        chk("b2b_last_word", data_read, 32'h66669999);
        @(negedge clk); #1;
        chk("b2b_ack_count", 32'(n_ack - a0), 32'd4);
        chk("b2b_rdy_count", 32'(n_rdy - r0), 32'd4);

        // Latency record: 5, 12, 7 cycles
        do_reset();
        xfer(1'b0, 22'h00001, 16'h0001, 1, 0, 16'h0, 16'h0, 3, 1'b0);
        chk("lat_5", 32'(lat_max), 32'd5);
        xfer(1'b0, 22'h00002, 16'h0002, 2, 0, 16'h0, 16'h0, 9, 1'b0);
        chk("lat_12", 32'(lat_max), 32'd12);
        xfer(1'b0, 22'h00003, 16'h0003, 1, 0, 16'h0, 16'h0, 5, 1'b0);
        chk("lat_keep_12", 32'(lat_max), 32'd12);

        // Timeout: controller never acks
        #1; a0 = n_ack;
        exp_q.push_back(exp_data);
        if (TOUT + 1 > exp_lat) exp_lat = TOUT + 1;
        rd = 1'b1; addr = 22'h00777;
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (rdy) begin k = i; break; end
        end
        rd = 1'b0;
        chk("tout_edge", 32'(k), 32'(TOUT + 2));
        chk("tout_req", 32'(sdram_req), 32'd0);
        chk("tout_flag", 32'(timeout), 32'd1);
        chk("tout_busy", 32'(busy), 32'd0);
        if (k != 0) sb_pop("tout_data");
        chk("tout_lat", 32'(lat_max), 32'(exp_lat));
        #1;
        chk("tout_no_ack", 32'(n_ack - a0), 32'd0);

        // Timeout stays sticky through a good read
        xfer(1'b1, 22'h00888, 16'h0, 1, 2, 16'hAAAA, 16'hBBBB, 0, 1'b0);
        chk("tout_sticky", 32'(timeout), 32'd1);
        chk("lat_after_tout", 32'(lat_max), 32'(TOUT + 1));

        // Reset in WAIT after beat 0
        rd = 1'b1; addr = 22'h3FFFFF;
        @(negedge clk);
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0; rd = 1'b0;
        sdram_dst = 1'b1; sdram_dout = 16'h7777;
        @(negedge clk);
        sdram_dst = 1'b0;
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_req", 32'(sdram_req), 32'd0);
        chk("mrst_data", data_read, 32'd0);
        chk("mrst_timeout", 32'(timeout), 32'd0);
        chk("mrst_lat", 32'(lat_max), 32'd0);
        chk("mrst_rnw", 32'(sdram_rnw), 32'd1);
        chk("mrst_addr", 32'(sdram_addr), 32'd0);
        sdram_rdy = 1'b1; sdram_ack = 1'b1;
        @(negedge clk);
        sdram_rdy = 1'b0; sdram_ack = 1'b0;
        chk("mrst_no_rdy", 32'(rdy), 32'd0);
        chk("mrst_no_ack", 32'(ack), 32'd0);
        chk("mrst_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
